seg_led_scan_ctrl: RTL and testbench
====================================

// Module: seg_led_scan_ctrl
// PURPOSE
//   Time-multiplexed scan scheduler for the 6-digit common-anode seven-segment display.
//   It shares one segment bus among six digit selects, one digit per time slot.
//   Each slot has a blanking gap before the digit is driven, to stop ghosting.
//   Display data arrives through a valid/ready handshake and only takes effect on a frame boundary.
//   Sits between the counter/value logic and the display pins; replaces static single-value drive.
// PARAMETERS
//   SHOW_CYCLES   50_000  clk cycles each digit is driven per slot (>=1)
//   BLANK_CYCLES  500     clk cycles all digits are off before each digit (0 = no gap)
// PORTS
//   clk         in   1   system clock
//   rst         in   1   reset, synchronous, active-high
//   en          in   1   display enable; 0 = all digits dark
//   data_valid  in   1   new display word offered
//   data_ready  out  1   scheduler can accept a word
//   data        in   24  six hex nibbles; data[3:0] = digit0 (rightmost), data[23:20] = digit5
//   dp          in   6   decimal point per digit, 1 = lit; captured with data
//   lz_blank    in   1   1 = suppress leading zeros (live, not captured)
//   sel         out  6   digit select, active-low, sel[i] drives digit i
//   seg_led     out  8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_done  out  1   1-cycle pulse when digit5 slot ends
// BEHAVIOUR
//   Reset:
//   - sel=6'h3F, seg_led=8'hFF, data_ready=1, frame_done=0.
//   - Digit index 0; state IDLE; active and pending words = 0; pending empty.
//   Outputs:
//   - All outputs are registered and update on the same edge as the state.
//   FSM IDLE:
//   - sel=3F, seg=FF.
//   - en=1 -> BLANK, index 0; go straight to SHOW if BLANK_CYCLES=0.
//   FSM BLANK:
//   - sel=3F, seg=FF for BLANK_CYCLES cycles, then SHOW.
//   FSM SHOW:
//   - sel = ~(1<<idx); seg = decode(nibble[idx]) with seg[7] = ~dp[idx]; lasts SHOW_CYCLES cycles.
//   - At slot end, idx<5: idx++ and go to BLANK.
//   - At slot end, idx==5: idx=0, frame_done=1 for one cycle, apply pending, go to BLANK.
//   en=0 in any state:
//   - Next cycle: IDLE, sel=3F, seg=FF, idx=0, slot counter cleared.
//   - Pending is kept.
//   Handshake:
//   - Transfer when data_valid & data_ready; {data,dp} go to pending and data_ready=0 next cycle.
//   - While running, pending becomes active on the frame_done cycle; data_ready=1 next cycle.
//   - In IDLE, pending becomes active on the cycle after acceptance; data_ready=1 the cycle after that.
//   - Valid while ready=0 is ignored; the sender holds it.
//   - Reset mid-operation drops pending and active words.
//   Decode (active-low, segments a-g):
//     0:C0  1:F9  2:A4  3:B0  4:99  5:92  6:82  7:F8
//     8:80  9:90  A:88  b:83  C:C6  d:A1  E:86  F:8E
//   Leading-zero blanking (lz_blank=1):
//   - Digit i>=1 shows seg[6:0]=7F when nibbles i..5 are all zero. Digit0 is never blanked.
//   - sel stays asserted and the dp bit still applies.
//   Counters and timing:
//   - Slot counter width is $clog2 of the larger of SHOW_CYCLES and BLANK_CYCLES. It is cleared on every state change.
//   - Frame period = 6*(SHOW_CYCLES+BLANK_CYCLES).
// TESTING (bench uses SHOW_CYCLES=4, BLANK_CYCLES=1)
//   1. Reset:
//      rst=1 for 2 cycles -> sel=3F, seg_led=FF, data_ready=1, frame_done=0.
//   2. Basic scan:
//      Load 24'h123456 with dp=0 in IDLE, then en=1 -> 1 cycle 3F/FF, then 4 cycles sel=3E, seg=82.
//      Digit5 then shows sel=1F, seg=F9; frame_done pulses every 30 cycles.
//   3. Leading-zero blanking:
//      data=24'h000120, lz_blank=1 -> digits 5..3 give seg=FF; digit2=F9, digit1=A4, digit0=C0.
//      With lz_blank=0, digits 5..3 give C0.
//   4. Tear-free update:
//      Offer 24'hABCDEF while digit2 of 123456 is shown -> data_ready=0.
//      Digits 3..5 still show 3,2,1; next frame digit0 shows 8E; data_ready=1 after frame_done.
//   5. Enable drop:
//      en=0 during digit3 SHOW -> next cycle sel=3F, seg=FF.
//      en=1 again -> restart at BLANK then digit0.
//   6. Decimal point and hold:
//      dp=6'b000001, data=123456 -> digit0 seg=02.
//      A second valid held while ready=0 is not accepted until after frame_done.

Source files
------------

// File: rtl/seg_led_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan scheduler.
// One digit is driven per time slot, each slot preceded by an all-dark
// blanking gap. New display words are staged in a pending register and only
// become visible at a frame boundary, or straight away while the display is idle.
module seg_led_scan_ctrl #(
   parameter int SHOW_CYCLES  = 50_000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic [23:0] data,
   input  logic [5:0]  dp,
   input  logic        lz_blank,
   output logic [5:0]  sel,
   output logic [7:0]  seg_led,
   output logic        frame_done
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam int BLANK_M1   = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_M1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   // After the last digit the next slot starts dark unless there is no gap.
   localparam logic [1:0] ST_SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

   logic [1:0]    state, state_n;
   logic [2:0]    idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [23:0]   act_data, act_data_n;
   logic [5:0]    act_dp, act_dp_n;
   logic [23:0]   pend_data;
   logic [5:0]    pend_dp;
   logic          pend_full;
   logic          promote;
   logic          accept;
   logic          fd_n;
   logic [5:0]    sel_n;
   logic [7:0]    seg_n;
   logic [23:0]   shifted;

   // Active-low a..g pattern for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   // Handshake: a word transfers on a cycle where data_valid and data_ready are
   // both high; data_ready then stays low until the staged word has been made
   // active and is released the cycle after that. The sender must hold
   // data_valid and its word while data_ready is low.
   assign accept = data_valid & data_ready;

   // Next scan position, slot timing and frame-boundary promotion of pending.
   always_comb begin
      state_n    = state;
      idx_n      = idx;
      cnt_n      = cnt + 1'b1;
      fd_n       = 1'b0;
      promote    = 1'b0;
      if (!en) begin
         state_n = ST_IDLE;
         idx_n   = 3'd0;
         cnt_n   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_n = ST_SLOT_START;
               idx_n   = 3'd0;
               cnt_n   = '0;
            end
            ST_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_n = ST_SHOW;
                  cnt_n   = '0;
               end
            end
            ST_SHOW: begin
               if (cnt == SHOW_LAST) begin
                  state_n = ST_SLOT_START;
                  cnt_n   = '0;
                  if (idx == 3'd5) begin
                     idx_n   = 3'd0;
                     fd_n    = 1'b1;
                     promote = pend_full;
                  end else begin
                     idx_n = idx + 3'd1;
                  end
               end
            end
            default: begin
               state_n = ST_IDLE;
               idx_n   = 3'd0;
               cnt_n   = '0;
            end
         endcase
      end
      // While idle there is no frame to tear, so a staged word goes live at once.
      if (state == ST_IDLE && pend_full) promote = 1'b1;
      act_data_n = promote ? pend_data : act_data;
      act_dp_n   = promote ? pend_dp   : act_dp;
   end

   // Registered digit select and segment pattern for the upcoming cycle.
   always_comb begin
      sel_n   = 6'h3F;
      seg_n   = 8'hFF;
      shifted = act_data_n >> {idx_n, 2'b00};
      if (state_n == ST_SHOW) begin
         sel_n = ~(6'd1 << idx_n);
         seg_n = {~act_dp_n[idx_n], decode(shifted[3:0])};
         if (lz_blank && idx_n != 3'd0 && shifted == 24'd0) seg_n[6:0] = 7'h7F;
      end
   end

   // State, counters, data registers, handshake and outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         cnt        <= '0;
         act_data   <= 24'd0;
         act_dp     <= 6'd0;
         pend_data  <= 24'd0;
         pend_dp    <= 6'd0;
         pend_full  <= 1'b0;
         data_ready <= 1'b1;
         sel        <= 6'h3F;
         seg_led    <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         act_data   <= act_data_n;
         act_dp     <= act_dp_n;
         sel        <= sel_n;
         seg_led    <= seg_n;
         frame_done <= fd_n;
         if (accept) begin
            pend_data  <= data;
            pend_dp    <= dp;
            pend_full  <= 1'b1;
            data_ready <= 1'b0;
         end else if (promote) begin
            pend_full <= 1'b0;
         end else if (!pend_full && !data_ready) begin
            data_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_led_scan_ctrl.sv
// Bench for seg_led_scan_ctrl with SHOW_CYCLES=4, BLANK_CYCLES=1.
// A position-in-frame model predicts outputs every cycle; directed steps
// add hand-computed literal checks at chosen points of the scan.
module tb_seg_led_scan_ctrl;

   localparam int SHOW  = 4;
   localparam int BLANK = 1;
   localparam int SLOT  = SHOW + BLANK;
   localparam int FRAME = 6 * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        data_valid;
   logic        data_ready;
   logic [23:0] data;
   logic [5:0]  dp;
   logic        lz_blank;
   logic [5:0]  sel;
   logic [7:0]  seg_led;
   logic        frame_done;

   int n_checks = 0;
   int n_errors = 0;

   seg_led_scan_ctrl #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst(rst), .en(en), .data_valid(data_valid), .data_ready(data_ready),
      .data(data), .dp(dp), .lz_blank(lz_blank), .sel(sel), .seg_led(seg_led),
      .frame_done(frame_done)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   bit          m_ok = 0;
   bit          m_run, m_ready, m_pend_full, m_rise_next, m_lz;
   int          m_t;
   logic [23:0] m_act, m_pend;
   logic [5:0]  m_adp, m_pend_dp;
   bit          mb_acc, mb_was_run, mb_prom;

   // Model: scan position is simply cycles since the display started running.
   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1; m_run = 0; m_t = 0; m_act = 0; m_adp = 0; m_pend = 0; m_pend_dp = 0;
         m_pend_full = 0; m_ready = 1; m_rise_next = 0; m_lz = lz_blank;
      end else if (m_ok) begin
         mb_acc     = data_valid && m_ready;
         mb_was_run = m_run;
         m_lz       = lz_blank;
         if (!en) begin
            m_run = 0; m_t = 0;
         end else if (!m_run) begin
            m_run = 1; m_t = 0;
         end else begin
            m_t++;
         end
         mb_prom = m_pend_full && (!mb_was_run || (m_run && m_t > 0 && m_t % FRAME == 0));
         if (m_rise_next) begin m_ready = 1; m_rise_next = 0; end
         if (mb_prom) begin
            m_act = m_pend; m_adp = m_pend_dp; m_pend_full = 0; m_rise_next = 1;
         end
         if (mb_acc) begin
            m_pend = data; m_pend_dp = dp; m_pend_full = 1; m_ready = 0;
         end
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      logic [5:0]  e_sel;
      logic [7:0]  e_seg;
      logic [23:0] hi;
      int          slot;
      if (m_ok) begin
         e_sel = 6'h3F;
         e_seg = 8'hFF;
         slot  = (m_t / SLOT) % 6;
         if (m_run && (m_t % SLOT) >= BLANK) begin
            hi    = m_act >> (4 * slot);
            e_sel = ~(6'd1 << slot);
            e_seg = {~m_adp[slot], seg_tab[hi[3:0]][6:0]};
            if (m_lz && slot >= 1 && hi == 24'd0) e_seg[6:0] = 7'h7F;
         end
         check("cyc_sel", 32'(sel), 32'(e_sel));
         check("cyc_seg", 32'(seg_led), 32'(e_seg));
         check("cyc_ready", 32'(data_ready), 32'(m_ready));
         check("cyc_frame_done", 32'(frame_done), 32'(m_run && m_t > 0 && m_t % FRAME == 0));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Offer a word and hold it until it is taken; reports cycles spent waiting.
   task automatic send(input logic [23:0] d, input logic [5:0] p, output int waited);
      data = d; dp = p; data_valid = 1'b1; waited = 0;
      while (!data_ready && waited < 200) begin
         tick();
         waited++;
      end
      if (!data_ready) begin
         n_checks++; n_errors++;
         $display("FAIL send_timeout: ready stayed 0 after %0d cycles", waited);
      end else begin
         tick();
      end
      data_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [5:0] s, input logic [7:0] g);
      check({name, "_sel"}, 32'(sel), 32'(s));
      check({name, "_seg"}, 32'(seg_led), 32'(g));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int w;
      rst = 1'b1; en = 1'b0; data_valid = 1'b0; data = 24'd0; dp = 6'd0; lz_blank = 1'b0;
      ticks(2);
      rst = 1'b0;
      expect_out("reset", 6'h3F, 8'hFF);
      check("reset_ready", 32'(data_ready), 32'd1);
      check("reset_fd", 32'(frame_done), 32'd0);

      // Basic scan: load in idle, then enable.
      send(24'h123456, 6'd0, w);
      check("idle_load_ready_low", 32'(data_ready), 32'd0);
      ticks(2);
      check("idle_load_ready_back", 32'(data_ready), 32'd1);
      en = 1'b1;
      tick();                                   // t=0
      expect_out("first_blank", 6'h3F, 8'hFF);
      tick();                                   // t=1
      expect_out("digit0", 6'h3E, 8'h82);
      ticks(25);                                // t=26
      expect_out("digit5", 6'h1F, 8'hF9);
      ticks(4);                                 // t=30
      check("fd_first", 32'(frame_done), 32'd1);
      tick();                                   // t=31
      check("fd_one_cycle", 32'(frame_done), 32'd0);
      ticks(29);                                // t=60
      check("fd_second", 32'(frame_done), 32'd1);

      // Tear-free update while digit2 is shown.
      ticks(11);                                // t=71
      expect_out("digit2", 6'h3B, 8'h99);
      send(24'hABCDEF, 6'd0, w);                // accepted, t=72
      check("update_ready_low", 32'(data_ready), 32'd0);
      ticks(5);                                 // t=77
      expect_out("old_digit3", 6'h37, 8'hB0);
      ticks(5);                                 // t=82
      expect_out("old_digit4", 6'h2F, 8'hA4);
      ticks(5);                                 // t=87
      expect_out("old_digit5", 6'h1F, 8'hF9);
      ticks(3);                                 // t=90
      check("update_fd", 32'(frame_done), 32'd1);
      check("update_ready_still_low", 32'(data_ready), 32'd0);
      tick();                                   // t=91
      check("update_ready_up", 32'(data_ready), 32'd1);
      expect_out("new_digit0", 6'h3E, 8'h8E);

      // Decimal point and a second word held while not ready.
      send(24'h123456, 6'b000001, w);           // t=92
      send(24'h000120, 6'd0, w);                // accepted at t=122
      check("held_wait_cycles", 32'(w), 32'd29);
      expect_out("dp_digit0", 6'h3E, 8'h02);
      check("held_ready_low", 32'(data_ready), 32'd0);

      // Leading-zero blanking (000120 becomes active at t=150).
      lz_blank = 1'b1;
      ticks(29);                                // t=151
      expect_out("lz_digit0", 6'h3E, 8'hC0);
      ticks(5);
      expect_out("lz_digit1", 6'h3D, 8'hA4);
      ticks(5);
      expect_out("lz_digit2", 6'h3B, 8'hF9);
      ticks(5);
      expect_out("lz_digit3", 6'h37, 8'hFF);
      ticks(10);                                // t=176
      expect_out("lz_digit5", 6'h1F, 8'hFF);
      lz_blank = 1'b0;
      tick();                                   // t=177
      expect_out("nolz_digit5", 6'h1F, 8'hC0);

      // Enable drop during digit3 show.
      ticks(19);                                // t=196
      expect_out("pre_drop_digit3", 6'h37, 8'hC0);
      en = 1'b0;
      tick();
      expect_out("drop_dark", 6'h3F, 8'hFF);
      ticks(3);
      expect_out("idle_dark", 6'h3F, 8'hFF);
      en = 1'b1;
      tick();
      expect_out("restart_blank", 6'h3F, 8'hFF);
      tick();
      expect_out("restart_digit0", 6'h3E, 8'hC0);

      // Reset mid-operation with a pending word: both words dropped.
      send(24'h999999, 6'h3F, w);
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      expect_out("midreset", 6'h3F, 8'hFF);
      check("midreset_ready", 32'(data_ready), 32'd1);
      ticks(2);
      en = 1'b1;
      ticks(2);
      expect_out("after_reset_digit0", 6'h3E, 8'hC0);
      ticks(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
